// File: rtl/clk_ctrl_pkg.sv
// Shared types and defaults for the clock ratio detector.
// Optional input synchronizer: define CLK_RATIO_DETECTOR_SYNC_EN.
package clk_ctrl_pkg;

   localparam int RATIO_WIDTH_DEF = 8;
   localparam int LOCK_COUNT_DEF  = 4;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2,
      STALL     = 2'd3
   } state_t;

   function automatic logic duty_bad(input int hi, input int lo);
      int diff;
      diff = (hi > lo) ? (hi - lo) : (lo - hi);
      return diff > 1;
   endfunction

endpackage

// File: rtl/clk_edge_detect.sv
// Rise/fall detector for the divided clock under measurement.
// CLK_RATIO_DETECTOR_SYNC_EN adds a two-flop synchronizer ahead of in_q.
module clk_edge_detect (
   input  logic clk,
   input  logic rest,
   input  logic div_clk_in,
   output logic rise,
   output logic fall
);

   logic in_q;
   logic src;

`ifdef CLK_RATIO_DETECTOR_SYNC_EN
   logic s1_q;
   logic s2_q;

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         in_q <= 1'b0;
      end else begin
         s1_q <= div_clk_in;
         s2_q <= s1_q;
         in_q <= s2_q;
      end
   end

   assign src = s2_q;
`else
   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         in_q <= 1'b0;
      end else begin
         in_q <= div_clk_in;
      end
   end

   assign src = div_clk_in;
`endif

   assign rise = src & ~in_q;
   assign fall = ~src & in_q;

endmodule

// File: rtl/clk_ratio_detector.sv
// Measures period and duty of a divided clock in clk cycles, with lock/stall.
// CLK_RATIO_DETECTOR_SYNC_EN enables the input synchronizer in clk_edge_detect.
module clk_ratio_detector
   import clk_ctrl_pkg::*;
#(
   parameter int ratio_width = RATIO_WIDTH_DEF,
   parameter int lock_count  = LOCK_COUNT_DEF
) (
   input  logic                   clk,
   input  logic                   rest,
   input  logic                   div_clk_in,
   output logic [ratio_width-1:0] measured_ratio,
   output logic [ratio_width-1:0] high_len,
   output logic [ratio_width-1:0] low_len,
   output logic                   meas_valid,
   output logic                   ratio_locked,
   output logic                   stalled,
   output logic                   duty_err
);

   localparam int MW = $clog2(lock_count + 1);
   localparam logic [ratio_width-1:0] MAX_W = '1;
   localparam logic [ratio_width-1:0] ONE_W = 1;
   localparam logic [MW-1:0]          ONE_M = 1;

   state_t                 state_q;
   logic [ratio_width-1:0] hi_cnt_q;
   logic [ratio_width-1:0] lo_cnt_q;
   logic [ratio_width-1:0] ratio_q;
   logic [ratio_width-1:0] high_q;
   logic [ratio_width-1:0] low_q;
   logic [MW-1:0]          match_q;
   logic                   valid_q;
   logic                   locked_q;
   logic                   stalled_q;
   logic                   duty_q;

   logic                   rise;
   logic                   fall;
   logic [ratio_width:0]   sum_d;
   logic [ratio_width-1:0] ratio_d;
   logic [ratio_width-1:0] hi_inc_d;
   logic [ratio_width-1:0] lo_inc_d;
   logic                   same_d;
   logic [MW-1:0]          match_d;
   logic                   locked_d;
   logic                   duty_d;

   clk_edge_detect u_edge (
      .clk        (clk),
      .rest       (rest),
      .div_clk_in (div_clk_in),
      .rise       (rise),
      .fall       (fall)
   );

   always_comb begin
      sum_d    = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
      ratio_d  = sum_d[ratio_width] ? MAX_W : sum_d[ratio_width-1:0];
      hi_inc_d = hi_cnt_q + ONE_W;
      lo_inc_d = lo_cnt_q + ONE_W;
      same_d   = (ratio_d == ratio_q);
      duty_d   = duty_bad(int'(hi_cnt_q), int'(lo_cnt_q));
      match_d  = ONE_M;
      if (same_d) begin
         match_d = (int'(match_q) >= lock_count) ? match_q : match_q + ONE_M;
      end
      locked_d = (int'(match_d) >= lock_count);
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q   <= IDLE;
         hi_cnt_q  <= '0;
         lo_cnt_q  <= '0;
         ratio_q   <= '0;
         high_q    <= '0;
         low_q     <= '0;
         match_q   <= '0;
         valid_q   <= 1'b0;
         locked_q  <= 1'b0;
         stalled_q <= 1'b0;
         duty_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE, STALL: begin
               if (rise) begin
                  state_q  <= MEAS_HIGH;
                  hi_cnt_q <= ONE_W;
                  lo_cnt_q <= ONE_W;
               end
            end
            MEAS_HIGH: begin
               if (fall) begin
                  state_q  <= MEAS_LOW;
                  lo_cnt_q <= ONE_W;
               end else if (hi_inc_d == MAX_W) begin
                  state_q   <= STALL;
                  hi_cnt_q  <= MAX_W;
                  stalled_q <= 1'b1;
                  locked_q  <= 1'b0;
                  match_q   <= '0;
               end else begin
                  hi_cnt_q <= hi_inc_d;
               end
            end
            MEAS_LOW: begin
               if (rise) begin
                  state_q   <= MEAS_HIGH;
                  high_q    <= hi_cnt_q;
                  low_q     <= lo_cnt_q;
                  ratio_q   <= ratio_d;
                  valid_q   <= 1'b1;
                  duty_q    <= duty_d;
                  stalled_q <= 1'b0;
                  match_q   <= match_d;
                  locked_q  <= locked_d;
                  hi_cnt_q  <= ONE_W;
               end else if (lo_inc_d == MAX_W) begin
                  state_q   <= STALL;
                  lo_cnt_q  <= MAX_W;
                  stalled_q <= 1'b1;
                  locked_q  <= 1'b0;
                  match_q   <= '0;
               end else begin
                  lo_cnt_q <= lo_inc_d;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign measured_ratio = ratio_q;
   assign high_len       = high_q;
   assign low_len        = low_q;
   assign meas_valid     = valid_q;
   assign ratio_locked   = locked_q;
   assign stalled        = stalled_q;
   assign duty_err       = duty_q;

endmodule
